// File: rtl/eth_latency_ping_scheduler.sv
// Ping/pong sequencer for the Ethernet latency measurer.
// Optional macro ETH_LATENCY_SEQ_CHECK_EN: accept rx strobes only for the current sequence.
module eth_latency_ping_scheduler #(
  parameter int C_TIME_WIDTH = 32,
  parameter int C_SEQ_WIDTH  = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    srst,
  input  logic [C_TIME_WIDTH-1:0] delay,
  input  logic [C_TIME_WIDTH-1:0] timeout,
  output logic                    tx_req,
  output logic [C_SEQ_WIDTH-1:0]  tx_seq,
  input  logic                    tx_ack,
  input  logic                    rx_ping,
  input  logic [C_SEQ_WIDTH-1:0]  rx_ping_seq,
  input  logic                    rx_pong,
  input  logic [C_SEQ_WIDTH-1:0]  rx_pong_seq,
  output logic [C_SEQ_WIDTH-1:0]  ping_count,
  output logic [C_TIME_WIDTH-1:0] ping_time,
  output logic [C_TIME_WIDTH-1:0] pong_time,
  output logic [C_SEQ_WIDTH-1:0]  pings_lost,
  output logic [C_SEQ_WIDTH-1:0]  pongs_lost,
  output logic                    result_valid
);

  localparam int TW = C_TIME_WIDTH;
  localparam int SW = C_SEQ_WIDTH;
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW:0]   TX_ONE = (TW+1)'(1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);

  typedef enum logic [1:0] {
    IDLE, SEND, WAIT_PONG, WAIT_DELAY
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] elapsed;
  logic [TW-1:0] interval;
  logic [TW-1:0] ping_mark;
  logic          ping_seen;

  logic          hs;
  logic          ping_hit;
  logic          pong_hit;
  logic          in_pong;
  logic          ping_acc;
  logic          pong_acc;
  logic          tmo_hit;
  logic          dly_hit;
  logic [TW:0]   elapsed_p1;
  logic [TW:0]   interval_p1;
  logic [TW:0]   tmo_lim;
  logic [TW:0]   dly_lim;

`ifdef ETH_LATENCY_SEQ_CHECK_EN
  logic [SW-1:0] cur_seq;
  assign cur_seq  = ping_count - S_ONE;
  assign ping_hit = rx_ping && (rx_ping_seq == cur_seq);
  assign pong_hit = rx_pong && (rx_pong_seq == cur_seq);
`else
  logic unused_seq;
  assign unused_seq = ^{rx_ping_seq, rx_pong_seq};
  assign ping_hit   = rx_ping;
  assign pong_hit   = rx_pong;
`endif

  // Limits of zero behave as one; compare one bit wider so +1 never wraps.
  always_comb begin
    elapsed_p1  = {1'b0, elapsed} + TX_ONE;
    interval_p1 = {1'b0, interval} + TX_ONE;
    tmo_lim     = (timeout == '0) ? TX_ONE : {1'b0, timeout};
    dly_lim     = (delay == '0) ? TX_ONE : {1'b0, delay};
  end

  assign hs       = tx_req && tx_ack;
  assign in_pong  = (state == WAIT_PONG) && enable;
  assign ping_acc = in_pong && ping_hit && !ping_seen;
  assign pong_acc = in_pong && pong_hit && ping_seen;
  assign tmo_hit  = in_pong && (elapsed_p1 >= tmo_lim) && !pong_acc;
  assign dly_hit  = (state == WAIT_DELAY) && (interval_p1 >= dly_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (srst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = SEND;
      end
      SEND: begin
        if (hs) state_nxt = enable ? WAIT_PONG : IDLE;
      end
      WAIT_PONG: begin
        if (!enable)
          state_nxt = IDLE;
        else if (pong_acc || tmo_hit)
          state_nxt = WAIT_DELAY;
      end
      WAIT_DELAY: begin
        if (!enable)
          state_nxt = IDLE;
        else if (dly_hit)
          state_nxt = SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_req = 1'b0;
    tx_seq = '0;
    if (state == SEND) begin
      tx_req = 1'b1;
      tx_seq = ping_count;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ping_count   <= '0;
      ping_time    <= '0;
      pong_time    <= '0;
      pings_lost   <= '0;
      pongs_lost   <= '0;
      result_valid <= 1'b0;
      elapsed      <= '0;
      interval     <= '0;
      ping_mark    <= '0;
      ping_seen    <= 1'b0;
    end else if (srst) begin
      ping_count   <= '0;
      ping_time    <= '0;
      pong_time    <= '0;
      pings_lost   <= '0;
      pongs_lost   <= '0;
      result_valid <= 1'b0;
      elapsed      <= '0;
      interval     <= '0;
      ping_mark    <= '0;
      ping_seen    <= 1'b0;
    end else begin
      result_valid <= pong_acc || tmo_hit;
      if (hs) begin
        ping_count <= ping_count + S_ONE;
        elapsed    <= '0;
        interval   <= '0;
        ping_seen  <= 1'b0;
      end else if (state == WAIT_PONG) begin
        if (!(&elapsed))  elapsed  <= elapsed + T_ONE;
        if (!(&interval)) interval <= interval + T_ONE;
      end else if (state == WAIT_DELAY) begin
        if (!(&interval)) interval <= interval + T_ONE;
      end
      if (ping_acc) begin
        ping_seen <= 1'b1;
        ping_time <= elapsed;
        ping_mark <= elapsed;
      end
      if (pong_acc) begin
        pong_time <= elapsed - ping_mark;
      end
      // Timeout overrides a ping accepted in the same cycle.
      if (tmo_hit) begin
        if (!ping_seen) begin
          pings_lost <= pings_lost + S_ONE;
          ping_time  <= '1;
          pong_time  <= '1;
        end else begin
          pongs_lost <= pongs_lost + S_ONE;
          pong_time  <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eth_latency_ping_scheduler.sv
// Table-driven bench for eth_latency_ping_scheduler.
// Honours ETH_LATENCY_SEQ_CHECK_EN for the sequence-filter case.
module tb_eth_latency_ping_scheduler;

  localparam int TW = 32;
  localparam int SW = 64;
  localparam logic [31:0] ONES = 32'hffff_ffff;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          srst = 1'b0;
  logic [TW-1:0] delay = '0;
  logic [TW-1:0] timeout = '0;
  logic          tx_req;
  logic [SW-1:0] tx_seq;
  logic          tx_ack = 1'b0;
  logic          rx_ping = 1'b0;
  logic [SW-1:0] rx_ping_seq = '0;
  logic          rx_pong = 1'b0;
  logic [SW-1:0] rx_pong_seq = '0;
  logic [SW-1:0] ping_count;
  logic [TW-1:0] ping_time;
  logic [TW-1:0] pong_time;
  logic [SW-1:0] pings_lost;
  logic [SW-1:0] pongs_lost;
  logic          result_valid;

  eth_latency_ping_scheduler #(
    .C_TIME_WIDTH(TW),
    .C_SEQ_WIDTH (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .srst        (srst),
    .delay       (delay),
    .timeout     (timeout),
    .tx_req      (tx_req),
    .tx_seq      (tx_seq),
    .tx_ack      (tx_ack),
    .rx_ping     (rx_ping),
    .rx_ping_seq (rx_ping_seq),
    .rx_pong     (rx_pong),
    .rx_pong_seq (rx_pong_seq),
    .ping_count  (ping_count),
    .ping_time   (ping_time),
    .pong_time   (pong_time),
    .pings_lost  (pings_lost),
    .pongs_lost  (pongs_lost),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tmo;
    int          dly;
    int          ping_at;
    int          pong_early;
    int          pong_at;
    logic [31:0] pt;
    logic [31:0] qt;
    int          dpl;
    int          dql;
    int          rv_at;
    int          next_at;
  } vec_t;

  typedef struct {
    logic [31:0] pt;
    logic [31:0] qt;
    logic [63:0] pl;
    logic [63:0] ql;
    int          rv_at;
  } exp_t;

  vec_t        vecs[8];
  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] m_cnt = '0;
  logic [63:0] m_pl = '0;
  logic [63:0] m_ql = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Wait for tx_req, load limits, ack after lat cycles; returns in cycle 0.
  task automatic do_send(input int lat, input int tmo, input int dly);
    int n;
    n = 0;
    while (!tx_req && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_req) begin
      $display("FAIL tx_req_wait: got 0, want 1");
      $fatal(1);
    end
    timeout = TW'(tmo);
    delay   = TW'(dly);
    chk("tx_seq", tx_seq, m_cnt);
    repeat (lat) @(negedge clk);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    m_cnt++;
    chk("ping_count", ping_count, m_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    exp_t x;
    int   pulses;
    bit   seen;
    bit   held;
    int   rv_k;

    //          tmo dly  ping pe  pong pt    qt    dpl dql rv  next
    vecs[0] = '{50, 100, 10, -1, 17, 32'd10, 32'd7,  0, 0, 18, 100};
    vecs[1] = '{20, 30,  25, -1, -1, ONES,   ONES,   1, 0, 20, 30};
    vecs[2] = '{20, 25,  5,  -1, -1, 32'd5,  ONES,   0, 1, 20, 25};
    vecs[3] = '{20, 0,   5,  -1, 19, 32'd5,  32'd14, 0, 0, 20, 21};
    vecs[4] = '{50, 10,  3,  -1, 30, 32'd3,  32'd27, 0, 0, 31, 32};
    vecs[5] = '{0,  0,   -1, -1, -1, ONES,   ONES,   1, 0, 1,  2};
    vecs[6] = '{20, 40,  8,  4,  12, 32'd8,  32'd4,  0, 0, 13, 40};
    vecs[7] = '{20, 15,  6,  6,  9,  32'd6,  32'd3,  0, 0, 10, 15};

    repeat (3) @(negedge clk);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_count", ping_count, 0);
    chk("rst_ping_time", ping_time, 0);
    chk("rst_pong_time", pong_time, 0);
    chk("rst_lost", {pings_lost | pongs_lost}, 0);
    chk("rst_rv", result_valid, 0);
    rst_n  = 1'b1;
    enable = 1'b1;

    foreach (vecs[i]) begin
      e = vecs[i];
      do_send(2, e.tmo, e.dly);
      rx_ping_seq = m_cnt - 1;
      rx_pong_seq = m_cnt - 1;
      m_pl += 64'(e.dpl);
      m_ql += 64'(e.dql);
      x = '{e.pt, e.qt, m_pl, m_ql, e.rv_at};
      sb.push_back(x);
      pulses = 0;
      seen   = 1'b0;
      for (int k = 0; k < 400; k++) begin
        rx_ping = 1'b0;
        rx_pong = 1'b0;
        if (result_valid) begin
          pulses++;
          if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
          end else begin
            x = sb.pop_front();
            chk("rv_cycle", 64'(k), 64'(x.rv_at));
            chk("ping_time", ping_time, x.pt);
            chk("pong_time", pong_time, x.qt);
            chk("pings_lost", pings_lost, x.pl);
            chk("pongs_lost", pongs_lost, x.ql);
          end
        end
        if (tx_req) begin
          chk("next_tx", 64'(k), 64'(e.next_at));
          seen = 1'b1;
          break;
        end
        rx_ping = (k == e.ping_at);
        rx_pong = (k == e.pong_at) || (k == e.pong_early);
        @(negedge clk);
      end
      chk("next_tx_seen", seen, 1);
      chk("rv_pulses", 64'(pulses), 1);
      chk("ping_time_hold", ping_time, e.pt);
    end

    // Enable dropped in SEND with a slow ack: request must persist.
    enable = 1'b0;
    held   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!tx_req) held = 1'b0;
    end
    chk("tx_req_held", held, 1);
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
    m_cnt++;
    chk("abort_count", ping_count, m_cnt);
    chk("abort_idle", tx_req, 0);
    repeat (3) @(negedge clk);
    chk("idle_stays", tx_req, 0);

    // Soft reset in the middle of WAIT_PONG, enable still high.
    enable = 1'b1;
    do_send(2, 50, 100);
    repeat (2) @(negedge clk);
    rx_ping = 1'b1;
    rx_ping_seq = m_cnt - 1;
    @(negedge clk);
    rx_ping = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_srst_ping", ping_time, 2);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    chk("srst_count", ping_count, 0);
    chk("srst_plost", pings_lost, 0);
    chk("srst_qlost", pongs_lost, 0);
    chk("srst_times", {ping_time, pong_time}, 0);
    chk("srst_idle", tx_req, 0);
    m_cnt = '0;
    @(negedge clk);
    chk("srst_resend", tx_req, 1);

    // Asynchronous reset while requesting.
    rst_n = 1'b0;
    #1;
    chk("async_tx_req", tx_req, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Four back-to-back timeouts bring ping_count to 5.
    repeat (4) do_send(0, 0, 0);
    do_send(0, 50, 100);
    chk("quick_plost", pings_lost, 4);
    rv_k = -1;
    for (int k = 0; k < 12; k++) begin
      rx_ping = 1'b0;
      rx_pong = 1'b0;
      if (result_valid && rv_k < 0) rv_k = k;
      if (k == 2) begin
        rx_ping = 1'b1;
        rx_ping_seq = 3;
      end
      if (k == 4) begin
        rx_ping = 1'b1;
        rx_ping_seq = 4;
      end
      if (k == 6) begin
        rx_pong = 1'b1;
        rx_pong_seq = 4;
      end
      @(negedge clk);
    end
    chk("seq_rv_cycle", 64'(rv_k), 7);
`ifdef ETH_LATENCY_SEQ_CHECK_EN
    chk("seq_ping_time", ping_time, 4);
    chk("seq_pong_time", pong_time, 2);
`else
    chk("seq_ping_time", ping_time, 2);
    chk("seq_pong_time", pong_time, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
